// File: rtl/multicycle_controller.sv
// Multicycle datapath control FSM: fetch/decode/execute sequencing with a
// bounded memory handshake wait and a sticky fault state.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          JUMP_EN     = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] oprtn,
  input  logic [5:0] fcn,
  input  logic       MemAck,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRd,
  output logic       MemWrt,
  output logic       MemtReg,
  output logic       RgWrt,
  output logic       destReg,
  output logic       ALUScA,
  output logic [1:0] ALUScB,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUOperation,
  output logic       Fault,
  output logic [3:0] State
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StAluWb  = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StJump   = 4'd9;
  localparam logic [3:0] StImmEx  = 4'd10;
  localparam logic [3:0] StImmWb  = 4'd11;
  localparam logic [3:0] StFault  = 4'd15;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  localparam logic [8:0] TimeoutW = 9'(MEM_TIMEOUT);

  logic [3:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // Low from reset until the first clock edge after release; holds off all requests.
  logic       run_q;

  logic       fn_valid;
  logic [3:0] fn_aluop;
  logic       in_wait;
  logic       wait_expired;

  always_comb begin
    fn_valid = 1'b1;
    fn_aluop = AluAnd;
    case (fcn)
      FnAdd:   fn_aluop = AluAdd;
      FnSub:   fn_aluop = AluSub;
      FnAnd:   fn_aluop = AluAnd;
      FnOr:    fn_aluop = AluOr;
      FnSlt:   fn_aluop = AluSlt;
      default: fn_valid = 1'b0;
    endcase
  end

  assign in_wait      = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // Expires on the cycle the count would reach the limit; a MemAck that cycle still wins.
  assign wait_expired = ({1'b0, cnt_q} + 9'd1) >= TimeoutW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (run_q) begin
      case (state_q)
        StFetch: begin
          if (MemAck) begin
            state_d = StDecode;
          end else if (wait_expired) begin
            state_d = StFault;
          end
        end
        StDecode: begin
          case (oprtn)
            OpLw, OpSw: state_d = StMemAdr;
            OpRType:    state_d = StExec;
            OpBeq:      state_d = StBranch;
            OpAddi:     state_d = StImmEx;
            OpJ:        state_d = JUMP_EN ? StJump : StFault;
            default:    state_d = StFault;
          endcase
        end
        StMemAdr: state_d = (oprtn == OpLw) ? StMemRd : StMemWr;
        StMemRd: begin
          if (MemAck) begin
            state_d = StMemWb;
          end else if (wait_expired) begin
            state_d = StFault;
          end
        end
        StMemWr: begin
          if (MemAck) begin
            state_d = StFetch;
          end else if (wait_expired) begin
            state_d = StFault;
          end
        end
        StMemWb:  state_d = StFetch;
        StExec:   state_d = fn_valid ? StAluWb : StFault;
        StAluWb:  state_d = StFetch;
        StBranch: state_d = StFetch;
        StJump:   state_d = StFetch;
        StImmEx:  state_d = StImmWb;
        StImmWb:  state_d = StFetch;
        StFault:  state_d = StFault;
        default:  state_d = StFault;
      endcase
      // Any transition clears the counter, so it always starts at zero on wait-state entry.
      cnt_d = (in_wait && (state_d == state_q)) ? cnt_q + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StFetch;
      cnt_q   <= 8'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    MemRd        = 1'b0;
    MemWrt       = 1'b0;
    MemtReg      = 1'b0;
    RgWrt        = 1'b0;
    destReg      = 1'b0;
    ALUScA       = 1'b0;
    ALUScB       = 2'd0;
    PCSrc        = 2'd0;
    ALUOperation = AluAnd;
    case (state_q)
      StFetch: begin
        MemRd        = 1'b1;
        ALUScB       = 2'd1;
        ALUOperation = AluAdd;
        PCWrite      = MemAck;
        IRWrite      = MemAck;
      end
      StDecode: begin
        ALUScB       = 2'd3;
        ALUOperation = AluAdd;
      end
      StMemAdr, StImmEx: begin
        ALUScA       = 1'b1;
        ALUScB       = 2'd2;
        ALUOperation = AluAdd;
      end
      StMemRd: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
      end
      StMemWr: begin
        MemWrt = 1'b1;
        IorD   = 1'b1;
      end
      StMemWb: begin
        RgWrt   = 1'b1;
        MemtReg = 1'b1;
      end
      StExec: begin
        ALUScA       = 1'b1;
        ALUOperation = fn_aluop;
      end
      StAluWb: begin
        RgWrt   = 1'b1;
        destReg = 1'b1;
      end
      StImmWb: RgWrt = 1'b1;
      StBranch: begin
        ALUScA       = 1'b1;
        ALUOperation = AluSub;
        PCSrc        = 2'd1;
        PCWrite      = Zero;
      end
      StJump: begin
        PCSrc   = 2'd2;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (!run_q) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
      RgWrt   = 1'b0;
      MemWrt  = 1'b0;
      MemRd   = 1'b0;
    end
  end

  assign Fault = (state_q == StFault);
  assign State = state_q;

endmodule
